ex_alu_stage: RTL



---
 rtl/pa_pkg.sv | 19 +
 rtl/pa_alu.sv | 44 ++++
 rtl/ex_alu_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pa_pkg.sv
// Shared definitions for the adder datapath: opcodes, default widths and
// the execute-stage buffer states.
package pa_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b10
   } state_e;

endpackage

// File: rtl/pa_alu.sv
// Combinational 2-bit-opcode ALU with signed-overflow flag; a zero
// destination forces both the result and the flag to zero.
module pa_alu
   import pa_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [1:0]        opcode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              dest_is_zero,
   output logic [DATA_W-1:0] result,
   output logic              overflow
);

   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;

   assign sum  = a + b;
   assign diff = a - b;

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (opcode)
         OP_ADD: begin
            result   = sum;
            overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
         end
         OP_SUB: begin
            result   = diff;
            overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
         end
         OP_AND:  result = a & b;
         default: result = a | b;
      endcase
      // Register 0 is hardwired to zero downstream, so never hand it a value.
      if (dest_is_zero) begin
         result   = '0;
         overflow = 1'b0;
      end
   end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU on accept, results held in a head/skid pair so that
// writeback backpressure never costs throughput.
module ex_alu_stage
   import pa_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_opcode,
   input  logic [ADDR_W-1:0] in_dest,
   input  logic [DATA_W-1:0] in_op_a,
   input  logic [DATA_W-1:0] in_op_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_write_addr,
   output logic [DATA_W-1:0] out_write_data,
   output logic              out_overflow,
   output logic [CNT_W-1:0]  retired_count
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and in_ready is purely registered.

   state_e            state;
   state_e            state_next;
   logic              accept;
   logic              deliver;
   logic              load_head_new;
   logic              load_head_skid;
   logic              load_skid;
   logic [DATA_W-1:0] alu_result;
   logic              alu_overflow;
   logic [ADDR_W-1:0] skid_addr;
   logic [DATA_W-1:0] skid_data;
   logic              skid_overflow;

   pa_alu #(.DATA_W(DATA_W)) u_alu (
      .opcode       (in_opcode),
      .a            (in_op_a),
      .b            (in_op_b),
      .dest_is_zero (in_dest == '0),
      .result       (alu_result),
      .overflow     (alu_overflow)
   );

   assign accept  = in_valid & in_ready;
   assign deliver = out_valid & out_ready;

   always_comb begin
      state_next     = state;
      load_head_new  = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               load_head_new = 1'b1;
               state_next    = ONE;
            end
         end
         ONE: begin
            if (accept && deliver) begin
               load_head_new = 1'b1;
            end else if (accept) begin
               load_skid  = 1'b1;
               state_next = TWO;
            end else if (deliver) begin
               state_next = EMPTY;
            end
         end
         TWO: begin
            if (deliver) begin
               load_head_skid = 1'b1;
               state_next     = ONE;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state     <= state_next;
         out_valid <= (state_next != EMPTY);
         in_ready  <= (state_next != TWO);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_write_addr <= '0;
         out_write_data <= '0;
         out_overflow   <= 1'b0;
         skid_addr      <= '0;
         skid_data      <= '0;
         skid_overflow  <= 1'b0;
      end else begin
         if (load_head_new) begin
            out_write_addr <= in_dest;
            out_write_data <= alu_result;
            out_overflow   <= alu_overflow;
         end else if (load_head_skid) begin
            out_write_addr <= skid_addr;
            out_write_data <= skid_data;
            out_overflow   <= skid_overflow;
         end
         if (load_skid) begin
            skid_addr     <= in_dest;
            skid_data     <= alu_result;
            skid_overflow <= alu_overflow;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_count <= '0;
      end else if (deliver) begin
         retired_count <= retired_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
